// File: rtl/elm_pkg.sv
// elm_pkg: shared LFSR constants, seed derivation, saturation and FSM state type
package elm_pkg;
  localparam int LFSR_W = 16;
  // Feedback taps for x^16+x^14+x^13+x^11+1 (state bits 15,13,12,10)
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_e;
  function automatic logic [LFSR_W-1:0] lfsr_seed(input logic [LFSR_W-1:0] base, input int n);
    logic [LFSR_W-1:0] s;
    s = base + LFSR_W'(n * 'h1111);
    return (s == '0) ? LFSR_W'(1) : s;
  endfunction
  function automatic logic signed [63:0] saturate(input logic signed [63:0] acc, input int out_w);
    logic signed [63:0] hi;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    return (acc > hi) ? hi : (acc < -hi - 64'sd1) ? -hi - 64'sd1 : acc;
  endfunction
endpackage

// File: rtl/elm_lfsr_weight.sv
// elm_lfsr_weight: seedable 16-bit Fibonacci LFSR presenting its low bits as a signed weight
module elm_lfsr_weight
  import elm_pkg::*;
#(
  parameter int                WGT_W = 11,
  parameter logic [LFSR_W-1:0] SEED  = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    step,
  output logic signed [WGT_W-1:0] wgt
);
  logic [LFSR_W-1:0] state_q, state_d;
  always_comb state_d = load ? SEED : step ? {state_q[LFSR_W-2:0], ^(state_q & LFSR_TAPS)} : state_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= SEED;
    else     state_q <= state_d;
  assign wgt = state_q[WGT_W-1:0];
endmodule

// File: rtl/elm_rwg_mac_engine.sv
// elm_rwg_mac_engine: multi-neuron random-weight MAC engine producing one saturated/ReLU
// activation vector per image of BEATS multi-pixel beats.
module elm_rwg_mac_engine
  import elm_pkg::*;
#(
  parameter int          PIX_W       = 8,
  parameter int          NPIX        = 16,
  parameter int          WGT_W       = 11,
  parameter int          NUM_NEURONS = 4,
  parameter int          BEATS       = 8,
  parameter int          ACC_W       = 32,
  parameter int          OUT_W       = 16,
  parameter logic [15:0] SEED_BASE   = 16'hACE1
) (
  input  logic                         clk2,
  input  logic                         reset_ap2,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NPIX*PIX_W-1:0]        in_data,
  input  logic                         mode,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_NEURONS*OUT_W-1:0] out_data,
  output logic                         busy
);
  localparam int PCW = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int BCW = (BEATS > 1) ? $clog2(BEATS) : 1;
  state_e                              state_q, state_d;
  logic [NPIX*PIX_W-1:0]               pix_q, pix_d;
  logic [PCW-1:0]                      pix_cnt_q, pix_cnt_d;
  logic [BCW-1:0]                      beat_cnt_q, beat_cnt_d;
  logic [NUM_NEURONS-1:0][ACC_W-1:0]   acc_q, acc_d;
  logic [NUM_NEURONS*OUT_W-1:0]        out_q, out_d, res;
  logic                                mode_q, mode_d, in_ready_q, in_ready_d;
  logic                                out_valid_q, out_valid_d, busy_q, busy_d;
  logic signed [WGT_W-1:0]             wgt [NUM_NEURONS];
  logic signed [PIX_W+WGT_W:0]         prod [NUM_NEURONS];
  logic signed [ACC_W-1:0]             acc_nxt [NUM_NEURONS];
  logic                                accept, first, mac;
  assign accept = in_valid & in_ready_q;
  assign first  = accept && beat_cnt_q == '0;
  assign mac    = state_q == MAC;
  for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_neuron
    elm_lfsr_weight #(.WGT_W(WGT_W), .SEED(lfsr_seed(SEED_BASE, n))) u_lfsr (
      .clk(clk2), .rst(reset_ap2), .load(first), .step(mac), .wgt(wgt[n])
    );
    assign prod[n]    = $signed({1'b0, pix_q[PIX_W-1:0]}) * wgt[n];
    assign acc_nxt[n] = $signed(acc_q[n]) + ACC_W'(prod[n]);
    // ReLU keys off the accumulator sign, which the clamp preserves
    assign res[n*OUT_W +: OUT_W] = (mode_q && acc_nxt[n][ACC_W-1]) ? '0
                                 : OUT_W'(saturate(64'(acc_nxt[n]), OUT_W));
  end
  always_comb begin
    state_d     = state_q;
    pix_d       = pix_q;
    pix_cnt_d   = pix_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    acc_d       = acc_q;
    out_d       = out_q;
    mode_d      = mode_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    if (state_q == IDLE && accept) begin
      pix_d      = in_data;
      state_d    = MAC;
      in_ready_d = 1'b0;
      if (first) begin
        acc_d  = '0;
        mode_d = mode;
        busy_d = 1'b1;
      end
    end else if (mac) begin
      pix_d     = pix_q >> PIX_W;
      pix_cnt_d = pix_cnt_q + 1'b1;
      for (int i = 0; i < NUM_NEURONS; i++) acc_d[i] = acc_nxt[i];
      if (pix_cnt_q == PCW'(NPIX - 1)) begin
        pix_cnt_d = '0;
        if (beat_cnt_q == BCW'(BEATS - 1)) begin
          beat_cnt_d  = '0;
          state_d     = OUT;
          out_d       = res;
          out_valid_d = 1'b1;
        end else begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          state_d    = IDLE;
          in_ready_d = 1'b1;
        end
      end
    end else if (state_q == OUT && out_ready) begin
      out_valid_d = 1'b0;
      busy_d      = 1'b0;
      state_d     = IDLE;
      in_ready_d  = 1'b1;
    end
  end
  always_ff @(posedge clk2 or posedge reset_ap2)
    if (reset_ap2) begin
      state_q     <= IDLE;
      pix_q       <= '0;
      pix_cnt_q   <= '0;
      beat_cnt_q  <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      mode_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_q       <= pix_d;
      pix_cnt_q   <= pix_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      mode_q      <= mode_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_q;
  assign busy      = busy_q;
endmodule
